cpu_2_debug_ocimem: RTL and testbench
=====================================

Name: cpu_2_debug_ocimem

Overview:
- Debug-side on-chip memory controller that sits directly downstream of the CPU debug-slave JTAG wrapper.
- Consumes its sysclk-domain command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a) and the 38-bit jdo word.
- Owns the monitor address register and the debug RAM, and returns MonDReg to the wrapper for shift-out.
- Also serves the CPU's debug-slave Avalon port, so JTAG and CPU share one single-port RAM under a small arbitration FSM.

Parameters:
ADDR_W, 8, word-address width; RAM depth = 2**ADDR_W 32-bit words
RAM_LAT, 1, RAM read latency in clk cycles (1 or 2)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data word from the debug-slave wrapper
take_action_ocimem_a  in  1  one-cycle strobe: load address (optionally read)
take_no_action_ocimem_a  in  1  one-cycle strobe: read at current address
take_action_ocimem_b  in  1  one-cycle strobe: write MonDReg to RAM
MonDReg  out  32  monitor data register, fed back to the wrapper
MonAReg  out  ADDR_W  monitor word address
jtag_busy  out  1  JTAG command pending or in service
jtag_overrun  out  1  sticky; JTAG strobe arrived while jtag_busy
avl_address  in  ADDR_W  CPU debug-slave word address
avl_read  in  1  Avalon read
avl_write  in  1  Avalon write
avl_writedata  in  32  write data
avl_byteenable  in  4  byte lanes
avl_debugaccess  in  1  write permitted only when 1
avl_readdata  out  32  read data
avl_waitrequest  out  1  Avalon stall

Behaviour:
- Reset (async, reset_n=0): MonDReg=0, MonAReg=0, avl_readdata=0, jtag_busy=0, jtag_overrun=0, FSM=IDLE.
- Asserting reset_n=0 mid-operation aborts any pending or in-flight access; no RAM write occurs after reset assertion.
- jdo decode:
  - take_action_ocimem_a: MonAReg<=jdo[17+ADDR_W-1:17]. If jdo[35]=1, queue a JTAG read.
  - take_no_action_ocimem_a: if jdo[35]=1, queue a JTAG read at the current MonAReg; otherwise no effect.
  - take_action_ocimem_b: MonDReg<=jdo[34:3] and queue a JTAG write of all four bytes.
- Queueing a command sets jtag_busy in the same edge. A strobe while jtag_busy=1 is ignored entirely (no MonAReg/MonDReg change) and sets jtag_overrun. jtag_overrun clears only on reset.
- FSM states:
  - IDLE
  - JRD (RAM_LAT cycles)
  - JWR (1 cycle)
  - ARD (RAM_LAT cycles)
  - AWR (1 cycle)
  - ADONE (1 cycle)
- IDLE priority: a pending JTAG command beats an Avalon request arriving in the same cycle. The Avalon request stays stalled and is served next.
- JRD: on its final cycle, MonDReg<=RAM[MonAReg], MonAReg<=MonAReg+1, jtag_busy<=0.
- JWR: RAM[MonAReg]<=MonDReg, MonAReg<=MonAReg+1, jtag_busy<=0.
- MonAReg increment wraps modulo 2**ADDR_W.
- ARD: on its final cycle, avl_readdata<=RAM[avl_address]; then ADONE.
- AWR:
  - If avl_debugaccess=1, write the byte lanes selected by avl_byteenable.
  - If avl_debugaccess=0, no write occurs, but the transfer still completes.
  - Then ADONE.
- avl_waitrequest = (avl_read|avl_write) & ~(state==ADONE). Asserted combinationally, so the master is released in ADONE. The FSM returns to IDLE after ADONE.
- Avalon read latency from IDLE acceptance: RAM_LAT+1 cycles to waitrequest low.
- Avalon write latency from IDLE acceptance: 2 cycles.
- Avalon inputs must stay stable while waitrequest=1; they are sampled on the final cycle of ARD/AWR.
- A JTAG strobe arriving during an Avalon access is queued (jtag_busy=1) and served after ADONE→IDLE.
- avl_read and avl_write both high is illegal; write takes precedence.
- MonDReg changes only on ocimem_b load or JRD completion. It is otherwise held, so a stable value is presented for the wrapper's capture.

Test Plan:
- Reset mid-stream: assert reset_n=0 during AWR -> RAM location unchanged, all outputs 0, waitrequest follows avl_read|avl_write only.
- JTAG write/read-back:
  - Stimulus: ocimem_a with jdo[17+:8]=0x10, jdo[35]=0; then ocimem_b with jdo[34:3]=0xDEADBEEF; then ocimem_a at 0x10 with jdo[35]=1.
  - Required: MonDReg=0xDEADBEEF; MonAReg=0x11 after each of the write and the read-back.
- Wrap: MonAReg=0xFF, take_no_action_ocimem_a with jdo[35]=1 -> MonDReg=RAM[0xFF], MonAReg=0x00.
- Avalon byte write:
  - Stimulus: RAM[5]=0x11223344; write 0xAABBCCDD with byteenable=4'b0101, debugaccess=1.
  - Required: RAM[5]=0x11BB33DD.
  - Repeat with debugaccess=0 -> unchanged, waitrequest still drops after 2 cycles.
- Collision: Avalon read of addr 3 and ocimem_b in the same cycle -> JTAG write serviced first, readdata returns the new value if MonAReg=3, waitrequest held throughout.
- Overrun: second ocimem_b one cycle after the first -> second ignored, MonDReg holds the first value, jtag_overrun=1 until reset.

Source files
------------

// File: rtl/cpu_2_debug_ocimem_if.sv
// rtl/cpu_2_debug_ocimem_if.sv - CPU debug-slave Avalon bus between the CPU and the debug OCI memory
interface cpu_2_debug_ocimem_if #(parameter int ADDR_W = 8);
   logic [ADDR_W-1:0] avl_address;
   logic              avl_read;
   logic              avl_write;
   logic [31:0]       avl_writedata;
   logic [3:0]        avl_byteenable;
   logic              avl_debugaccess;
   logic [31:0]       avl_readdata;
   logic              avl_waitrequest;

   modport master (
      output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable, avl_debugaccess,
      input  avl_readdata, avl_waitrequest
   );

   modport slave (
      input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable, avl_debugaccess,
      output avl_readdata, avl_waitrequest
   );
endinterface

// File: rtl/cpu_2_debug_ocimem.sv
// rtl/cpu_2_debug_ocimem.sv - debug RAM shared between JTAG monitor commands and the CPU debug-slave port
module cpu_2_debug_ocimem #(
   parameter int ADDR_W  = 8,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   output logic [31:0]       MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              jtag_busy,
   output logic              jtag_overrun,
   cpu_2_debug_ocimem_if.slave avl
);
   typedef enum logic [2:0] {IDLE, JRD, JWR, ARD, AWR, ADONE} state_t;

   localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

   state_t      state, next;
   logic [1:0]  lat_cnt;
   logic        rd_last;
   logic        jtag_wr;
   logic [31:0] rdata_q;
   logic [31:0] mem [0:(2**ADDR_W)-1];

   logic              strobe, accept, q_new, q_wr;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_be;
   logic              jrd_done, jwr_done, ard_done;
   logic              unused_jdo;

   assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

   // A command queued this cycle already counts as pending, so it beats a same-cycle Avalon request
   assign strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign accept = strobe & ~jtag_busy;
   assign q_new  = accept & (take_action_ocimem_b |
                             ((take_action_ocimem_a | take_no_action_ocimem_a) & jdo[35]));
   assign q_wr   = take_action_ocimem_b;
   assign rd_last = (lat_cnt == LAT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         lat_cnt <= '0;
      end else begin
         state   <= next;
         lat_cnt <= ((state == JRD || state == ARD) && !rd_last) ? lat_cnt + 2'd1 : 2'd0;
      end
   end

   always_comb begin
      next      = state;
      mem_we    = 1'b0;
      mem_addr  = MonAReg;
      mem_wdata = MonDReg;
      mem_be    = 4'hF;
      jrd_done  = 1'b0;
      jwr_done  = 1'b0;
      ard_done  = 1'b0;
      case (state)
         IDLE: begin
            if (jtag_busy)
               next = jtag_wr ? JWR : JRD;
            else if (q_new)
               next = q_wr ? JWR : JRD;
            else if (avl.avl_write)
               next = AWR;
            else if (avl.avl_read)
               next = ARD;
         end
         JRD: begin
            if (rd_last) begin
               jrd_done = 1'b1;
               next     = IDLE;
            end
         end
         JWR: begin
            mem_we   = 1'b1;
            jwr_done = 1'b1;
            next     = IDLE;
         end
         ARD: begin
            if (rd_last) begin
               ard_done = 1'b1;
               next     = ADONE;
            end
         end
         AWR: begin
            mem_we    = avl.avl_debugaccess;
            mem_addr  = avl.avl_address;
            mem_wdata = avl.avl_writedata;
            mem_be    = avl.avl_byteenable;
            next      = ADONE;
         end
         ADONE:   next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we && reset_n) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b])
               mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         MonDReg      <= '0;
         MonAReg      <= '0;
         jtag_busy    <= 1'b0;
         jtag_wr      <= 1'b0;
         jtag_overrun <= 1'b0;
         rdata_q      <= '0;
      end else begin
         if (jrd_done) begin
            MonDReg   <= mem[MonAReg];
            MonAReg   <= MonAReg + 1'b1;
            jtag_busy <= 1'b0;
         end
         if (jwr_done) begin
            MonAReg   <= MonAReg + 1'b1;
            jtag_busy <= 1'b0;
         end
         if (ard_done)
            rdata_q <= mem[avl.avl_address];
         // busy is still 1 on a completion cycle, so strobes here never collide with the updates above
         if (strobe && jtag_busy) begin
            jtag_overrun <= 1'b1;
         end else if (accept) begin
            if (take_action_ocimem_b)
               MonDReg <= jdo[34:3];
            else if (take_action_ocimem_a)
               MonAReg <= jdo[17 +: ADDR_W];
            if (q_new) begin
               jtag_busy <= 1'b1;
               jtag_wr   <= q_wr;
            end
         end
      end
   end

   assign avl.avl_readdata    = rdata_q;
   assign avl.avl_waitrequest = (avl.avl_read | avl.avl_write) & (state != ADONE);
endmodule

// File: tb/tb_cpu_2_debug_ocimem.sv
// tb/tb_cpu_2_debug_ocimem.sv - directed checks of JTAG/Avalon access to the debug RAM
module tb_cpu_2_debug_ocimem;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [37:0] jdo = '0;
   logic        take_a = 1'b0, take_na = 1'b0, take_b = 1'b0;
   logic [31:0] MonDReg;
   logic [7:0]  MonAReg;
   logic        jtag_busy, jtag_overrun;
   int          n_assert = 0;
   int          n_fail = 0;
   int          cyc;

   cpu_2_debug_ocimem_if #(.ADDR_W(8)) avl_bus ();

   cpu_2_debug_ocimem #(.ADDR_W(8), .RAM_LAT(1)) dut (
      .clk(clk), .reset_n(reset_n), .jdo(jdo),
      .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_na), .take_action_ocimem_b(take_b),
      .MonDReg(MonDReg), .MonAReg(MonAReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
      .avl(avl_bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic jtag(input logic a, input logic na, input logic b, input logic [37:0] d);
      take_a = a; take_na = na; take_b = b; jdo = d;
      tick();
      take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
   endtask

   task automatic wait_jtag();
      int n = 0;
      while (jtag_busy && n < 20) begin
         tick();
         n++;
      end
      chk("jtag_done", 32'(jtag_busy), 32'd0);
   endtask

   task automatic avl_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic dbg, output int c);
      avl_bus.avl_address = addr; avl_bus.avl_writedata = data; avl_bus.avl_byteenable = be;
      avl_bus.avl_debugaccess = dbg; avl_bus.avl_write = wr; avl_bus.avl_read = ~wr;
      c = 0;
      do begin
         tick();
         c++;
      end while (avl_bus.avl_waitrequest && c < 20);
      avl_bus.avl_read = 1'b0; avl_bus.avl_write = 1'b0;
      tick();
   endtask

   initial begin
      avl_bus.avl_address = '0; avl_bus.avl_read = 1'b0; avl_bus.avl_write = 1'b0;
      avl_bus.avl_writedata = '0; avl_bus.avl_byteenable = '0; avl_bus.avl_debugaccess = 1'b0;
      #12;
      chk("rst_mondreg", MonDReg, 32'h0);
      chk("rst_monareg", 32'(MonAReg), 32'h0);
      chk("rst_readdata", avl_bus.avl_readdata, 32'h0);
      chk("rst_busy", 32'(jtag_busy), 32'h0);
      chk("rst_overrun", 32'(jtag_overrun), 32'h0);
      chk("rst_waitreq", 32'(avl_bus.avl_waitrequest), 32'h0);
      reset_n = 1'b1;
      tick();

      // JTAG write/read-back at 0x10
      jtag(1, 0, 0, 38'(32'h10) << 17);
      chk("a_load_addr", 32'(MonAReg), 32'h10);
      chk("a_noread_busy", 32'(jtag_busy), 32'h0);
      jtag(0, 0, 1, 38'(32'hDEADBEEF) << 3);
      chk("b_busy", 32'(jtag_busy), 32'h1);
      chk("b_mondreg", MonDReg, 32'hDEADBEEF);
      wait_jtag();
      chk("wr_monareg", 32'(MonAReg), 32'h11);
      jtag(0, 0, 1, 38'(32'h12345678) << 3);
      wait_jtag();
      chk("wr2_monareg", 32'(MonAReg), 32'h12);
      jtag(1, 0, 0, (38'd1 << 35) | (38'(32'h10) << 17));
      wait_jtag();
      chk("rdback_data", MonDReg, 32'hDEADBEEF);
      chk("rdback_monareg", 32'(MonAReg), 32'h11);

      // Wrap at the top of the address space
      jtag(1, 0, 0, 38'(32'hFF) << 17);
      jtag(0, 0, 1, 38'(32'hCAFEF00D) << 3);
      wait_jtag();
      chk("wr_wrap", 32'(MonAReg), 32'h00);
      jtag(0, 0, 1, 38'(32'h0BADC0DE) << 3);
      wait_jtag();
      jtag(1, 0, 0, 38'(32'hFF) << 17);
      jtag(0, 1, 0, 38'h0);
      chk("na_noop_busy", 32'(jtag_busy), 32'h0);
      chk("na_noop_addr", 32'(MonAReg), 32'hFF);
      jtag(0, 1, 0, 38'd1 << 35);
      wait_jtag();
      chk("rd_wrap_data", MonDReg, 32'hCAFEF00D);
      chk("rd_wrap_addr", 32'(MonAReg), 32'h00);

      // Avalon byte-lane writes and debugaccess gating
      avl_xfer(1, 8'd5, 32'h11223344, 4'hF, 1, cyc);
      chk("avl_wr_lat", 32'(cyc), 32'd2);
      avl_xfer(1, 8'd5, 32'hAABBCCDD, 4'b0101, 1, cyc);
      avl_xfer(0, 8'd5, 32'h0, 4'h0, 0, cyc);
      chk("avl_rd_lat", 32'(cyc), 32'd2);
      chk("avl_byte_wr", avl_bus.avl_readdata, 32'h11BB33DD);
      avl_xfer(1, 8'd5, 32'hFFFFFFFF, 4'hF, 0, cyc);
      chk("avl_nodbg_lat", 32'(cyc), 32'd2);
      avl_xfer(0, 8'd5, 32'h0, 4'h0, 0, cyc);
      chk("avl_nodbg_data", avl_bus.avl_readdata, 32'h11BB33DD);
      avl_xfer(0, 8'd0, 32'h0, 4'h0, 0, cyc);
      chk("avl_rd_jtagdata", avl_bus.avl_readdata, 32'h0BADC0DE);

      // Collision: Avalon read of 3 and JTAG write to 3 in the same cycle
      jtag(1, 0, 0, 38'(32'h03) << 17);
      avl_bus.avl_address = 8'd3; avl_bus.avl_read = 1'b1;
      take_b = 1'b1; jdo = 38'(32'h5A5A1234) << 3;
      tick();
      take_b = 1'b0;
      chk("col_busy", 32'(jtag_busy), 32'h1);
      chk("col_waitreq", 32'(avl_bus.avl_waitrequest), 32'h1);
      cyc = 1;
      while (avl_bus.avl_waitrequest && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("col_lat", 32'(cyc), 32'd4);
      chk("col_readdata", avl_bus.avl_readdata, 32'h5A5A1234);
      chk("col_monareg", 32'(MonAReg), 32'h04);
      avl_bus.avl_read = 1'b0;
      tick();

      // Overrun: back-to-back ocimem_b
      jtag(0, 0, 1, 38'(32'h11110000) << 3);
      jtag(0, 0, 1, 38'(32'h22220000) << 3);
      chk("ovr_flag", 32'(jtag_overrun), 32'h1);
      chk("ovr_mondreg", MonDReg, 32'h11110000);
      wait_jtag();
      chk("ovr_monareg", 32'(MonAReg), 32'h05);
      tick(); tick();
      chk("ovr_sticky", 32'(jtag_overrun), 32'h1);

      // Reset asserted during AWR
      avl_xfer(1, 8'd7, 32'h01020304, 4'hF, 1, cyc);
      avl_bus.avl_address = 8'd7; avl_bus.avl_writedata = 32'h99999999;
      avl_bus.avl_byteenable = 4'hF; avl_bus.avl_debugaccess = 1'b1; avl_bus.avl_write = 1'b1;
      tick();
      reset_n = 1'b0;
      #1;
      chk("mrst_mondreg", MonDReg, 32'h0);
      chk("mrst_monareg", 32'(MonAReg), 32'h0);
      chk("mrst_readdata", avl_bus.avl_readdata, 32'h0);
      chk("mrst_overrun", 32'(jtag_overrun), 32'h0);
      chk("mrst_waitreq_hi", 32'(avl_bus.avl_waitrequest), 32'h1);
      tick();
      avl_bus.avl_write = 1'b0;
      #1;
      chk("mrst_waitreq_lo", 32'(avl_bus.avl_waitrequest), 32'h0);
      reset_n = 1'b1;
      tick();
      avl_xfer(0, 8'd7, 32'h0, 4'h0, 0, cyc);
      chk("mrst_ram_kept", avl_bus.avl_readdata, 32'h01020304);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
